// File: rtl/match_controller_pkg.sv
// Shared codes for the match sequencer: phase encoding, round/match winner codes,
// the player controller state set, and small saturating helpers.
package match_controller_pkg;

    typedef enum logic [2:0] {
        P_IDLE      = 3'd0,
        P_COUNTDOWN = 3'd1,
        P_FIGHT     = 3'd2,
        P_KO        = 3'd3,
        P_MATCH_END = 3'd4
    } phase_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Player controller state codes, shared with the gameplay controllers.
    localparam logic [3:0] S_IDLE         = 4'd0;
    localparam logic [3:0] S_WALK_FWD     = 4'd1;
    localparam logic [3:0] S_WALK_BACK    = 4'd2;
    localparam logic [3:0] S_CROUCH       = 4'd3;
    localparam logic [3:0] S_JUMP         = 4'd4;
    localparam logic [3:0] S_PUNCH        = 4'd5;
    localparam logic [3:0] S_KICK         = 4'd6;
    localparam logic [3:0] S_BLOCK        = 4'd7;
    localparam logic [3:0] S_CROUCH_BLOCK = 4'd8;
    localparam logic [3:0] S_HITSTUN      = 4'd9;
    localparam logic [3:0] S_BLOCKSTUN    = 4'd10;

    function automatic logic [1:0] sat_dec2(input logic [1:0] v);
        return (v == 2'd0) ? 2'd0 : v - 2'd1;
    endfunction

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? 2'd3 : v + 2'd1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/match_controller_hit_edge_detect.sv
// Flags the first cycle a player enters HITSTUN. The previous-state register
// tracks every cycle so a stun held across a phase change never counts twice.
module hit_edge_detect
    import match_controller_pkg::*;
(
    input  logic       logic_clk,
    input  logic       reset,
    input  logic [3:0] state,
    input  logic       enable,
    output logic       hit
);

    logic [3:0] prev_q;
    logic [3:0] prev_d;

    always_comb begin
        prev_d = state;
    end

    always_ff @(posedge logic_clk or posedge reset) begin
        if (reset) begin
            prev_q <= S_IDLE;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign hit = enable && (state == S_HITSTUN) && (prev_q != S_HITSTUN);

endmodule

// File: rtl/match_controller.sv
// Best-of-N match sequencer: countdown, live fight window, health, round clock,
// KO/timeout resolution and round tally, all outputs registered.
module match_controller
    import match_controller_pkg::*;
#(
    parameter int HEALTH_MAX       = 3,
    parameter int ROUNDS_TO_WIN    = 2,
    parameter int FRAMES_PER_SEC   = 60,
    parameter int ROUND_SECONDS    = 60,
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int KO_HOLD_FRAMES   = 120
)
(
    input  logic       logic_clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] p1_state,
    input  logic [3:0] p2_state,
    output logic [2:0] phase,
    output logic       freeze,
    output logic       player_reset,
    output logic [1:0] p1_health,
    output logic [1:0] p2_health,
    output logic [1:0] p1_rounds,
    output logic [1:0] p2_rounds,
    output logic [6:0] round_timer,
    output logic [1:0] winner
);

    // One frame counter serves countdown, fight seconds and the KO hold.
    localparam int CNT_W = $clog2(max3(COUNTDOWN_FRAMES, KO_HOLD_FRAMES, FRAMES_PER_SEC) + 1);

    localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(COUNTDOWN_FRAMES - 1);
    localparam logic [CNT_W-1:0] KO_LAST  = CNT_W'(KO_HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0] SEC_LAST = CNT_W'(FRAMES_PER_SEC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [1:0]       HEALTH_INIT = 2'(HEALTH_MAX);
    localparam logic [1:0]       ROUNDS_WIN  = 2'(ROUNDS_TO_WIN);
    localparam logic [6:0]       TIMER_INIT  = 7'(ROUND_SECONDS);

    phase_t           phase_q, phase_d;
    logic             freeze_q, freeze_d;
    logic             player_reset_q, player_reset_d;
    logic [1:0]       p1_health_q, p1_health_d;
    logic [1:0]       p2_health_q, p2_health_d;
    logic [1:0]       p1_rounds_q, p1_rounds_d;
    logic [1:0]       p2_rounds_q, p2_rounds_d;
    logic [6:0]       timer_q, timer_d;
    logic [1:0]       winner_q, winner_d;
    logic [CNT_W-1:0] frame_q, frame_d;

    logic       fight_en;
    logic       p1_hit, p2_hit;
    logic [1:0] p1_health_nx, p2_health_nx;
    logic [6:0] timer_nx;
    logic       round_over;
    logic [1:0] round_result;
    logic       enter_countdown;

    assign fight_en = (phase_q == P_FIGHT);

    hit_edge_detect u_p1_hit (
        .logic_clk (logic_clk),
        .reset     (reset),
        .state     (p1_state),
        .enable    (fight_en),
        .hit       (p1_hit)
    );

    hit_edge_detect u_p2_hit (
        .logic_clk (logic_clk),
        .reset     (reset),
        .state     (p2_state),
        .enable    (fight_en),
        .hit       (p2_hit)
    );

    always_comb begin
        phase_d         = phase_q;
        player_reset_d  = 1'b0;
        p1_health_d     = p1_health_q;
        p2_health_d     = p2_health_q;
        p1_rounds_d     = p1_rounds_q;
        p2_rounds_d     = p2_rounds_q;
        timer_d         = timer_q;
        winner_d        = winner_q;
        frame_d         = frame_q;
        enter_countdown = 1'b0;
        round_over      = 1'b0;
        round_result    = WIN_NONE;

        p1_health_nx = p1_hit ? sat_dec2(p1_health_q) : p1_health_q;
        p2_health_nx = p2_hit ? sat_dec2(p2_health_q) : p2_health_q;
        timer_nx     = timer_q;
        if (frame_q == SEC_LAST && timer_q != 7'd0) begin
            timer_nx = timer_q - 7'd1;
        end

        case (phase_q)
            P_IDLE: begin
                if (start) begin
                    p1_rounds_d     = 2'd0;
                    p2_rounds_d     = 2'd0;
                    winner_d        = WIN_NONE;
                    enter_countdown = 1'b1;
                end
            end
            P_COUNTDOWN: begin
                if (frame_q == CD_LAST) begin
                    phase_d = P_FIGHT;
                    frame_d = '0;
                end else begin
                    frame_d = frame_q + CNT_ONE;
                end
            end
            P_FIGHT: begin
                p1_health_d = p1_health_nx;
                p2_health_d = p2_health_nx;
                timer_d     = timer_nx;
                frame_d     = (frame_q == SEC_LAST) ? '0 : frame_q + CNT_ONE;

                // KO outranks the clock, so a lethal hit on the last tick is decided by health.
                if (p1_health_nx == 2'd0 && p2_health_nx == 2'd0) begin
                    round_over   = 1'b1;
                    round_result = WIN_DRAW;
                end else if (p1_health_nx == 2'd0) begin
                    round_over   = 1'b1;
                    round_result = WIN_P2;
                end else if (p2_health_nx == 2'd0) begin
                    round_over   = 1'b1;
                    round_result = WIN_P1;
                end else if (timer_nx == 7'd0) begin
                    round_over = 1'b1;
                    if (p1_health_nx > p2_health_nx) begin
                        round_result = WIN_P1;
                    end else if (p2_health_nx > p1_health_nx) begin
                        round_result = WIN_P2;
                    end else begin
                        round_result = WIN_DRAW;
                    end
                end

                if (round_over) begin
                    winner_d = round_result;
                    if (round_result == WIN_P1) begin
                        p1_rounds_d = sat_inc2(p1_rounds_q);
                    end
                    if (round_result == WIN_P2) begin
                        p2_rounds_d = sat_inc2(p2_rounds_q);
                    end
                    phase_d = P_KO;
                    frame_d = '0;
                end
            end
            P_KO: begin
                if (frame_q == KO_LAST) begin
                    if (p1_rounds_q == ROUNDS_WIN || p2_rounds_q == ROUNDS_WIN) begin
                        phase_d  = P_MATCH_END;
                        winner_d = (p1_rounds_q == ROUNDS_WIN) ? WIN_P1 : WIN_P2;
                        frame_d  = '0;
                    end else begin
                        enter_countdown = 1'b1;
                    end
                end else begin
                    frame_d = frame_q + CNT_ONE;
                end
            end
            P_MATCH_END: begin
                if (start) begin
                    p1_rounds_d     = 2'd0;
                    p2_rounds_d     = 2'd0;
                    enter_countdown = 1'b1;
                end
            end
            default: begin
                phase_d = P_IDLE;
                frame_d = '0;
            end
        endcase

        if (enter_countdown) begin
            phase_d        = P_COUNTDOWN;
            player_reset_d = 1'b1;
            p1_health_d    = HEALTH_INIT;
            p2_health_d    = HEALTH_INIT;
            timer_d        = TIMER_INIT;
            frame_d        = '0;
            winner_d       = WIN_NONE;
        end

        freeze_d = (phase_d != P_FIGHT);
    end

    always_ff @(posedge logic_clk or posedge reset) begin
        if (reset) begin
            phase_q        <= P_IDLE;
            freeze_q       <= 1'b1;
            player_reset_q <= 1'b0;
            p1_health_q    <= HEALTH_INIT;
            p2_health_q    <= HEALTH_INIT;
            p1_rounds_q    <= 2'd0;
            p2_rounds_q    <= 2'd0;
            timer_q        <= TIMER_INIT;
            winner_q       <= WIN_NONE;
            frame_q        <= '0;
        end else begin
            phase_q        <= phase_d;
            freeze_q       <= freeze_d;
            player_reset_q <= player_reset_d;
            p1_health_q    <= p1_health_d;
            p2_health_q    <= p2_health_d;
            p1_rounds_q    <= p1_rounds_d;
            p2_rounds_q    <= p2_rounds_d;
            timer_q        <= timer_d;
            winner_q       <= winner_d;
            frame_q        <= frame_d;
        end
    end

    assign phase        = phase_q;
    assign freeze       = freeze_q;
    assign player_reset = player_reset_q;
    assign p1_health    = p1_health_q;
    assign p2_health    = p2_health_q;
    assign p1_rounds    = p1_rounds_q;
    assign p2_rounds    = p2_rounds_q;
    assign round_timer  = timer_q;
    assign winner       = winner_q;

endmodule
